mod_time_counter: RTL and testbench
===================================

MOD_TIME_COUNTER -- requirements
Module: mod_time_counter

Interface
REQ-001 Parameter WIDTH, default 6, sets the counter value width in bits.
REQ-002 Parameter MODULUS, default 60, sets the count range 0..MODULUS-1. Legal only if 2 <= MODULUS <= 2**WIDTH.
REQ-003 Parameter INIT_VAL, default 0, is the value after reset and after clear. Legal only if < MODULUS.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 en  input  1  count enable for tick-driven counting; level.
REQ-007 tick_in  input  1  carry level from the lower time stage; its rising edge requests one step.
REQ-008 dir  input  1  count direction: 0 = up, 1 = down.
REQ-009 clear  input  1  synchronous return to INIT_VAL.
REQ-010 load_en  input  1  synchronous load strobe.
REQ-011 load_val  input  WIDTH  value loaded when load_en=1.
REQ-012 adj_up  input  1  manual +1 adjust pulse; generates no carry.
REQ-013 adj_dn  input  1  manual -1 adjust pulse; generates no carry.
REQ-014 out  output  WIDTH  registered count value.
REQ-015 carry_out  output  1  registered one-cycle wrap/borrow pulse, for cascading.
REQ-016 at_limit  output  1  registered flag: 1 when out == MODULUS-1 (dir=0) or out == 0 (dir=1).
REQ-017 load_err  output  1  registered one-cycle pulse for an out-of-range load.

Function
REQ-018 The block SHALL register tick_in into tick_d each cycle; tick_step = tick_in & ~tick_d & en.
REQ-019 Per-edge priority SHALL be: clear > load_en > (adj_up xor adj_dn) > tick_step. Exactly one action SHALL occur per cycle.
REQ-020 Clear SHALL set out = INIT_VAL and carry_out = 0.
REQ-021 Load with load_val < MODULUS SHALL set out = load_val.
REQ-022 Load with load_val >= MODULUS SHALL set out = MODULUS-1 and pulse load_err for one cycle.
REQ-023 Adjust SHALL step out by ±1 modulo MODULUS: up from MODULUS-1 goes to 0; down from 0 goes to MODULUS-1. carry_out SHALL stay 0.
REQ-024 adj_up and adj_dn asserted together SHALL cause no change and SHALL fall through to tick_step evaluation.
REQ-025 Tick up SHALL work as follows:
- out == MODULUS-1: out becomes 0 and carry_out = 1.
- otherwise: out becomes out+1.
REQ-026 Tick down SHALL work as follows:
- out == 0: out becomes MODULUS-1 and carry_out = 1.
- otherwise: out becomes out-1.
REQ-027 carry_out SHALL be asserted for exactly the cycle following the updating edge and SHALL be 0 in every other cycle.
REQ-028 Latency from the tick_in rising edge being sampled to the out update SHALL be one clock; the same edge registers carry_out.
REQ-029 A tick_step that loses priority (clear, load or adjust in the same cycle) SHALL be discarded, not queued.
REQ-030 tick_in held high SHALL produce exactly one step.
REQ-031 A tick_in rising edge while en=0 SHALL be ignored, with tick_d still updated.
REQ-032 at_limit SHALL be derived from the registered out and the current dir. Any dir change SHALL be reflected in at_limit on the next cycle.
REQ-033 All arithmetic SHALL be done in WIDTH bits. out SHALL never hold a value >= MODULUS.
REQ-034 A change of dir SHALL take effect on the next tick_step without altering out.

Reset
REQ-035 While reset=1 the block SHALL hold, independent of clk: out = INIT_VAL, carry_out = 0, load_err = 0, tick_d = 0, at_limit per INIT_VAL.
REQ-036 Reset asserted mid-count SHALL discard any pending tick edge.
REQ-037 After reset release, a tick_in already high SHALL be seen as a rising edge on the first clock.

Verification
REQ-038 Wrap-up (defaults, en=1, dir=0): 60 tick_in edges from 0 -> out = 1..59, then 0. carry_out pulses once, in the cycle after the 59->0 edge.
REQ-039 Borrow-down (dir=1, out=0): one tick edge -> out = 59 and a one-cycle carry_out.
REQ-040 Load checks:
- load_val = 37 -> out = 37, load_err = 0.
- load_val = 63 -> out = 59, load_err pulse.
- load_en together with a tick edge -> tick lost, carry_out = 0.
REQ-041 Adjust checks:
- adj_up at 59 -> 0 with carry_out = 0.
- adj_up together with adj_dn -> no change.
- tick_in held high 10 cycles -> exactly one step.
REQ-042 Async reset: assert reset between clock edges at out = 42 -> out = 0 immediately. Release with tick_in = 1 -> out = 1 after the first clock.
REQ-043 Parametrised instance WIDTH=4, MODULUS=10, INIT_VAL=1:
- 9 -> 0 with carry_out.
- load_val = 12 -> out = 9 plus load_err.

Source files
------------

// File: rtl/mod_time_counter.sv
// mod_time_counter: modulo-MODULUS up/down time-stage counter with cascade carry, load, clear and manual adjust.
// Ports: clk, reset (async, active-high) | en, tick_in (carry level from lower stage), dir (0 up / 1 down),
//        clear, load_en/load_val, adj_up/adj_dn | out, carry_out (wrap/borrow pulse), at_limit, load_err (bad load pulse)
module mod_time_counter #(
    parameter int WIDTH    = 6,
    parameter int MODULUS  = 60,
    parameter int INIT_VAL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             tick_in,
    input  logic             dir,
    input  logic             clear,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_val,
    input  logic             adj_up,
    input  logic             adj_dn,
    output logic [WIDTH-1:0] out,
    output logic             carry_out,
    output logic             at_limit,
    output logic             load_err
);
    localparam logic [WIDTH-1:0] MAX   = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] INIT  = WIDTH'(INIT_VAL);
    // one extra bit so MODULUS == 2**WIDTH is still representable
    localparam logic [WIDTH:0]   MOD_W = (WIDTH + 1)'(MODULUS);
    logic             tick_d;
    logic             tick_step;
    logic             over;
    logic [WIDTH-1:0] inc;
    logic [WIDTH-1:0] dec;
    logic [WIDTH-1:0] nxt;
    logic             nxt_carry;
    logic             nxt_err;
    assign tick_step = tick_in & ~tick_d & en;
    assign over      = {1'b0, load_val} >= MOD_W;
    assign inc       = (out == MAX) ? '0 : out + WIDTH'(1);
    assign dec       = (out == '0) ? MAX : out - WIDTH'(1);
    always_comb begin
        nxt       = out;
        nxt_carry = 1'b0;
        nxt_err   = 1'b0;
        if (clear) begin
            nxt = INIT;
        end else if (load_en) begin
            nxt     = over ? MAX : load_val;
            nxt_err = over;
        end else if (adj_up ^ adj_dn) begin
            nxt = adj_up ? inc : dec;
        end else if (tick_step) begin
            nxt       = dir ? dec : inc;
            nxt_carry = dir ? (out == '0) : (out == MAX);
        end
    end
    // at_limit tracks the value being registered, judged against the current dir
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_d    <= 1'b0;
            out       <= INIT;
            carry_out <= 1'b0;
            load_err  <= 1'b0;
            at_limit  <= (INIT == MAX);
        end else begin
            tick_d    <= tick_in;
            out       <= nxt;
            carry_out <= nxt_carry;
            load_err  <= nxt_err;
            at_limit  <= dir ? (nxt == '0) : (nxt == MAX);
        end
    end
endmodule

// File: tb/tb_mod_time_counter.sv
// tb_mod_time_counter: directed checks of mod_time_counter, default and WIDTH=4/MODULUS=10/INIT_VAL=1 instances.
module tb_mod_time_counter;
    logic       clk = 1'b0;
    logic       reset;
    logic       a_en, a_tick, a_dir, a_clear, a_load, a_up, a_dn;
    logic [5:0] a_val;
    logic [5:0] a_out;
    logic       a_carry, a_lim, a_err;
    logic       b_en, b_tick, b_dir, b_clear, b_load, b_up, b_dn;
    logic [3:0] b_val;
    logic [3:0] b_out;
    logic       b_carry, b_lim, b_err;
    int         errors = 0;
    int         checks = 0;
    always #5 clk = ~clk;
    mod_time_counter dut_a (
        .clk(clk), .reset(reset), .en(a_en), .tick_in(a_tick), .dir(a_dir), .clear(a_clear),
        .load_en(a_load), .load_val(a_val), .adj_up(a_up), .adj_dn(a_dn),
        .out(a_out), .carry_out(a_carry), .at_limit(a_lim), .load_err(a_err)
    );
    mod_time_counter #(.WIDTH(4), .MODULUS(10), .INIT_VAL(1)) dut_b (
        .clk(clk), .reset(reset), .en(b_en), .tick_in(b_tick), .dir(b_dir), .clear(b_clear),
        .load_en(b_load), .load_val(b_val), .adj_up(b_up), .adj_dn(b_dn),
        .out(b_out), .carry_out(b_carry), .at_limit(b_lim), .load_err(b_err)
    );
    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    initial begin
        reset = 1'b1;
        {a_en, a_tick, a_dir, a_clear, a_load, a_up, a_dn} = 7'b1000000;
        a_val = '0;
        {b_en, b_tick, b_dir, b_clear, b_load, b_up, b_dn} = 7'b0;
        b_val = '0;
        #3;
        chk("rst_out", a_out, 0);
        chk("rst_carry", a_carry, 0);
        chk("rst_err", a_err, 0);
        chk("rst_lim", a_lim, 0);
        chk("rst_b_out", b_out, 1);
        step();
        reset = 1'b0;
        step();
        chk("idle_out", a_out, 0);
        // wrap-up: 60 edges, single carry after 59->0
        for (int i = 1; i <= 60; i++) begin
            a_tick = 1'b1;
            step();
            chk("wrap_out", a_out, i % 60);
            chk("wrap_carry", a_carry, (i == 60) ? 1 : 0);
            if (i == 59) chk("wrap_lim59", a_lim, 1);
            a_tick = 1'b0;
            step();
            chk("wrap_carry_low", a_carry, 0);
        end
        // borrow down from 0
        a_dir = 1'b1;
        step();
        chk("dir_lim", a_lim, 1);
        chk("dir_out_kept", a_out, 0);
        a_tick = 1'b1;
        step();
        chk("borrow_out", a_out, 59);
        chk("borrow_carry", a_carry, 1);
        a_tick = 1'b0;
        step();
        chk("borrow_carry_low", a_carry, 0);
        // loads
        a_dir = 1'b0;
        a_load = 1'b1;
        a_val = 6'd37;
        step();
        chk("load37_out", a_out, 37);
        chk("load37_err", a_err, 0);
        a_val = 6'd63;
        step();
        chk("load63_out", a_out, 59);
        chk("load63_err", a_err, 1);
        a_load = 1'b0;
        step();
        chk("load63_err_low", a_err, 0);
        chk("load63_lim", a_lim, 1);
        // load wins over a wrapping tick; the tick is dropped
        a_load = 1'b1;
        a_val = 6'd10;
        a_tick = 1'b1;
        step();
        chk("loadtick_out", a_out, 10);
        chk("loadtick_carry", a_carry, 0);
        a_load = 1'b0;
        step();
        chk("loadtick_noqueue", a_out, 10);
        a_tick = 1'b0;
        step();
        // adjust
        a_load = 1'b1;
        a_val = 6'd59;
        step();
        a_load = 1'b0;
        a_up = 1'b1;
        step();
        chk("adjup_out", a_out, 0);
        chk("adjup_carry", a_carry, 0);
        a_up = 1'b0;
        a_dn = 1'b1;
        step();
        chk("adjdn_out", a_out, 59);
        chk("adjdn_carry", a_carry, 0);
        a_up = 1'b1;
        step();
        chk("adjboth_out", a_out, 59);
        a_tick = 1'b1;
        step();
        chk("adjboth_tick_out", a_out, 0);
        chk("adjboth_tick_carry", a_carry, 1);
        a_up = 1'b0;
        a_dn = 1'b0;
        a_tick = 1'b0;
        step();
        // held-high tick gives one step
        a_tick = 1'b1;
        for (int i = 0; i < 10; i++) step();
        chk("held_out", a_out, 1);
        a_tick = 1'b0;
        step();
        // edge while disabled is consumed
        a_en = 1'b0;
        a_tick = 1'b1;
        step();
        chk("en0_out", a_out, 1);
        a_en = 1'b1;
        step();
        chk("en0_late_out", a_out, 1);
        a_tick = 1'b0;
        step();
        // async reset mid-cycle, release with tick_in high
        a_load = 1'b1;
        a_val = 6'd42;
        step();
        a_load = 1'b0;
        chk("pre_rst_out", a_out, 42);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_out", a_out, 0);
        a_tick = 1'b1;
        #1;
        reset = 1'b0;
        step();
        chk("rst_release_out", a_out, 1);
        a_tick = 1'b0;
        a_clear = 1'b1;
        step();
        chk("clear_out", a_out, 0);
        a_clear = 1'b0;
        // parametrised instance
        chk("b_init", b_out, 1);
        b_en = 1'b1;
        b_load = 1'b1;
        b_val = 4'd9;
        step();
        b_load = 1'b0;
        chk("b_load9", b_out, 9);
        chk("b_lim9", b_lim, 1);
        b_tick = 1'b1;
        step();
        chk("b_wrap_out", b_out, 0);
        chk("b_wrap_carry", b_carry, 1);
        b_tick = 1'b0;
        step();
        chk("b_carry_low", b_carry, 0);
        b_load = 1'b1;
        b_val = 4'd12;
        step();
        b_load = 1'b0;
        chk("b_load12_out", b_out, 9);
        chk("b_load12_err", b_err, 1);
        b_clear = 1'b1;
        step();
        chk("b_clear_out", b_out, 1);
        chk("b_err_low", b_err, 0);
        b_clear = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
